// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, operand-forward
//   select codes and the saturating performance-counter increment.
// No logic of its own; imported by pipeline_ctrl and hazard_fwd_unit.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   // Operand source for the Exec-stage ALU inputs
   localparam logic [1:0] FWD_RF  = 2'b00;  // register file read
   localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result sitting in Mem
   localparam logic [1:0] FWD_WB  = 2'b10;  // write data in WB

   localparam int CNT_W = 32;

   // Counters stick at all-ones rather than wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_fwd_unit.sv
// hazard_fwd_unit: load-use hazard detection and operand forward selection.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides what to do with the hazard flag.
// Ports: rs1/rs2 (+used) of the Dec instruction; rd/wen of Exec/Mem/WB;
//   load flags of Exec/Mem -> load_use, fwd_a_sel, fwd_b_sel.
module hazard_fwd_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs1_dec,
   input  logic [REG_AW-1:0] rs2_dec,
   input  logic              rs1_used,
   input  logic              rs2_used,
   input  logic [REG_AW-1:0] rd_exec,
   input  logic [REG_AW-1:0] rd_mem,
   input  logic [REG_AW-1:0] rd_wb,
   input  logic              wen_exec,
   input  logic              wen_mem,
   input  logic              wen_wb,
   input  logic              load_exec,
   input  logic              load_mem,
   output logic              load_use,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel
);

   // x0 is hard-wired zero, so a match on it is never a real dependency
   logic rs1_nz, rs2_nz;
   assign rs1_nz = (rs1_dec != '0);
   assign rs2_nz = (rs2_dec != '0);

   // A load still in Exec or Mem has no data yet: that is the only case
   // forwarding cannot cover.
   logic ld_exec_w, ld_mem_w;
   assign ld_exec_w = load_exec & wen_exec;
   assign ld_mem_w  = load_mem  & wen_mem;

   logic rs1_haz, rs2_haz;
   assign rs1_haz = rs1_used & rs1_nz &
                    ((ld_exec_w & (rs1_dec == rd_exec)) | (ld_mem_w & (rs1_dec == rd_mem)));
   assign rs2_haz = rs2_used & rs2_nz &
                    ((ld_exec_w & (rs2_dec == rd_exec)) | (ld_mem_w & (rs2_dec == rd_mem)));
   assign load_use = rs1_haz | rs2_haz;

   // The Mem-stage ALU result is the younger value, so it wins over WB
   logic mem_alu_w;
   assign mem_alu_w = wen_mem & ~load_mem;

   always_comb begin
      fwd_a_sel = FWD_RF;
      fwd_b_sel = FWD_RF;
      if (rs1_nz) begin
         if (mem_alu_w && (rs1_dec == rd_mem))   fwd_a_sel = FWD_MEM;
         else if (wen_wb && (rs1_dec == rd_wb))  fwd_a_sel = FWD_WB;
      end
      if (rs2_nz) begin
         if (mem_alu_w && (rs2_dec == rd_mem))   fwd_b_sel = FWD_MEM;
         else if (wen_wb && (rs2_dec == rd_wb))  fwd_b_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline stall/flush/forward control, halt drain FSM
//   and saturating stall/flush performance counters.
// Latency: stall/flush/forward outputs combinational; halted registered.
// Backpressure: load-use stalls IF/Dec and bubbles Exec; redirect overrides.
// Ports: clk, rstn; hazard inputs (rs/rd/wen/load per stage), redirect_mem,
//   halt_if -> stall_if/dec, bubble_exec, flush_dec/exec/mem, fwd_a/b_sel,
//   halted, stall_cnt, flush_cnt.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int HALT_DRAIN = 4   // 1..15
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [REG_AW-1:0] rs1_dec,
   input  logic [REG_AW-1:0] rs2_dec,
   input  logic              rs1_used,
   input  logic              rs2_used,
   input  logic [REG_AW-1:0] rd_exec,
   input  logic [REG_AW-1:0] rd_mem,
   input  logic [REG_AW-1:0] rd_wb,
   input  logic              wen_exec,
   input  logic              wen_mem,
   input  logic              wen_wb,
   input  logic              load_exec,
   input  logic              load_mem,
   input  logic              redirect_mem,
   input  logic              halt_if,
   output logic              stall_if,
   output logic              stall_dec,
   output logic              bubble_exec,
   output logic              flush_dec,
   output logic              flush_exec,
   output logic              flush_mem,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              halted,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   localparam logic [3:0] DRAIN_INIT = 4'(HALT_DRAIN);

   state_e           state_q, state_d;
   logic [3:0]       drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use;

   hazard_fwd_unit #(.REG_AW(REG_AW)) u_hazard_fwd (
      .rs1_dec   (rs1_dec),
      .rs2_dec   (rs2_dec),
      .rs1_used  (rs1_used),
      .rs2_used  (rs2_used),
      .rd_exec   (rd_exec),
      .rd_mem    (rd_mem),
      .rd_wb     (rd_wb),
      .wen_exec  (wen_exec),
      .wen_mem   (wen_mem),
      .wen_wb    (wen_wb),
      .load_exec (load_exec),
      .load_mem  (load_mem),
      .load_use  (load_use),
      .fwd_a_sel (fwd_a_sel),
      .fwd_b_sel (fwd_b_sel)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      stall_if    = 1'b0;
      stall_dec   = 1'b0;
      bubble_exec = 1'b0;
      flush_dec   = 1'b0;
      flush_exec  = 1'b0;
      flush_mem   = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            // A taken redirect makes the younger stages (and any hazard
            // among them) irrelevant, so flush wins over stall.
            if (redirect_mem) begin
               flush_dec  = 1'b1;
               flush_exec = 1'b1;
               flush_mem  = 1'b1;
            end else if (load_use) begin
               stall_if    = 1'b1;
               stall_dec   = 1'b1;
               bubble_exec = 1'b1;
            end
            // A halt fetched on a wrong path is discarded by the redirect
            if (halt_if && !redirect_mem) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_INIT;
            end
         end

         ST_DRAIN: begin
            if (redirect_mem) begin
               // The halt was speculative; resume normal fetch
               flush_dec   = 1'b1;
               flush_exec  = 1'b1;
               flush_mem   = 1'b1;
               state_d     = ST_RUN;
               drain_cnt_d = '0;
            end else begin
               stall_if = 1'b1;
               if (load_use) begin
                  // Nothing advances during a stall, so the drain pauses
                  stall_dec   = 1'b1;
                  bubble_exec = 1'b1;
               end else if (drain_cnt_q <= 4'd1) begin
                  state_d     = ST_HALTED;
                  drain_cnt_d = '0;
               end else begin
                  drain_cnt_d = drain_cnt_q - 4'd1;
               end
            end
         end

         ST_HALTED: begin
            stall_if    = 1'b1;
            stall_dec   = 1'b1;
            bubble_exec = 1'b1;
         end

         default: begin
            state_d     = ST_RUN;
            drain_cnt_d = '0;
         end
      endcase
   end

   // Once halted the core is frozen, so nothing further is counted
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q != ST_HALTED) begin
         if (stall_dec)    stall_cnt_d = sat_inc(stall_cnt_q);
         if (redirect_mem) flush_cnt_d = sat_inc(flush_cnt_q);
      end
   end

   assign halted    = (state_q == ST_HALTED);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: combinational vector table, directed
//   multi-cycle sequences (load-use, redirect, halt/drain, saturation) and a
//   randomized run against a behavioural reference model.
module tb_pipeline_ctrl;

   localparam int AW = 5;
   localparam int HD = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [AW-1:0] rs1_dec, rs2_dec, rd_exec, rd_mem, rd_wb;
   logic          rs1_used, rs2_used, wen_exec, wen_mem, wen_wb;
   logic          load_exec, load_mem, redirect_mem, halt_if;
   logic          stall_if, stall_dec, bubble_exec;
   logic          flush_dec, flush_exec, flush_mem, halted;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic [31:0]   stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipeline_ctrl #(.REG_AW(AW), .HALT_DRAIN(HD)) dut (
      .clk(clk), .rstn(rstn),
      .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rs1_used(rs1_used), .rs2_used(rs2_used),
      .rd_exec(rd_exec), .rd_mem(rd_mem), .rd_wb(rd_wb),
      .wen_exec(wen_exec), .wen_mem(wen_mem), .wen_wb(wen_wb),
      .load_exec(load_exec), .load_mem(load_mem),
      .redirect_mem(redirect_mem), .halt_if(halt_if),
      .stall_if(stall_if), .stall_dec(stall_dec), .bubble_exec(bubble_exec),
      .flush_dec(flush_dec), .flush_exec(flush_exec), .flush_mem(flush_mem),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct packed {
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rde, rdm, rdw;
      logic       we, wm, ww, le, lm, redir, halt;
   } in_t;

   // {stall_if, stall_dec, bubble_exec, flush_dec, flush_exec, flush_mem, fwd_a, fwd_b}
   typedef struct packed {
      logic       si, sd, bub, fd, fe, fm;
      logic [1:0] fa, fb;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   function automatic in_t mk(input int rs1, input int rs2, input int u1, input int u2,
                              input int rde, input int rdm, input int rdw,
                              input int we, input int wm, input int ww,
                              input int le, input int lm, input int redir);
      in_t v;
      v       = '0;
      v.rs1   = 5'(rs1);  v.rs2 = 5'(rs2);
      v.u1    = 1'(u1);   v.u2  = 1'(u2);
      v.rde   = 5'(rde);  v.rdm = 5'(rdm); v.rdw = 5'(rdw);
      v.we    = 1'(we);   v.wm  = 1'(wm);  v.ww  = 1'(ww);
      v.le    = 1'(le);   v.lm  = 1'(lm);
      v.redir = 1'(redir);
      return v;
   endfunction

   task automatic drive(input in_t v);
      rs1_dec = v.rs1;  rs2_dec = v.rs2;  rs1_used = v.u1;  rs2_used = v.u2;
      rd_exec = v.rde;  rd_mem  = v.rdm;  rd_wb    = v.rdw;
      wen_exec = v.we;  wen_mem = v.wm;   wen_wb   = v.ww;
      load_exec = v.le; load_mem = v.lm;
      redirect_mem = v.redir; halt_if = v.halt;
   endtask

   function automatic out_t outs();
      out_t r;
      r.si = stall_if;  r.sd = stall_dec;  r.bub = bubble_exec;
      r.fd = flush_dec; r.fe = flush_exec; r.fm  = flush_mem;
      r.fa = fwd_a_sel; r.fb = fwd_b_sel;
      return r;
   endfunction

   task automatic do_reset();
      drive('0);
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // ---------------- reference model ----------------
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
   int     m_mode;
   int     m_left;
   longint m_sc, m_fc;

   function automatic bit m_hazard(input in_t v);
      logic [4:0] src [2];
      bit         use_ [2];
      bit         h;
      src[0] = v.rs1; src[1] = v.rs2; use_[0] = v.u1; use_[1] = v.u2;
      h = 0;
      for (int k = 0; k < 2; k++) begin
         if (use_[k] && src[k] != 0) begin
            if (src[k] == v.rde && v.le && v.we) h = 1;
            if (src[k] == v.rdm && v.lm && v.wm) h = 1;
         end
      end
      return h;
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] rs, input in_t v);
      if (rs == 0) return 2'b00;
      if (rs == v.rdm && v.wm && !v.lm) return 2'b01;
      if (rs == v.rdw && v.ww) return 2'b10;
      return 2'b00;
   endfunction

   function automatic out_t m_out(input in_t v);
      out_t r;
      bit   h;
      r  = '0;
      h  = m_hazard(v);
      r.fa = m_fwd(v.rs1, v);
      r.fb = m_fwd(v.rs2, v);
      if (m_mode == M_HALT) begin
         r.si = 1; r.sd = 1; r.bub = 1;
      end else if (v.redir) begin
         r.fd = 1; r.fe = 1; r.fm = 1;
      end else begin
         if (h) begin r.si = 1; r.sd = 1; r.bub = 1; end
         if (m_mode == M_DRAIN) r.si = 1;
      end
      return r;
   endfunction

   task automatic m_step(input in_t v);
      out_t r;
      bit   h;
      r = m_out(v);
      h = m_hazard(v);
      if (m_mode != M_HALT) begin
         if (r.sd && m_sc < 64'hFFFF_FFFF) m_sc++;
         if (v.redir && m_fc < 64'hFFFF_FFFF) m_fc++;
      end
      case (m_mode)
         M_RUN: if (v.halt && !v.redir) begin m_mode = M_DRAIN; m_left = HD; end
         M_DRAIN: begin
            if (v.redir) m_mode = M_RUN;
            else if (!h) begin
               m_left--;
               if (m_left == 0) m_mode = M_HALT;
            end
         end
         default: ;
      endcase
   endtask

   task automatic m_reset();
      m_mode = M_RUN; m_left = 0; m_sc = 0; m_fc = 0;
   endtask

   // ---------------- stimulus ----------------
   vec_t tbl [14];
   in_t  v, lu_exec, lu_mem, hv;
   out_t e;
   bit   seen;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      lu_exec = mk(5,0,1,0, 5,0,0, 1,0,0, 1,0, 0);
      lu_mem  = mk(5,0,1,0, 0,5,0, 0,1,0, 0,1, 0);

      tbl[0]  = '{mk(0,0,0,0, 0,0,0, 0,0,0, 0,0, 0), 10'b000_000_00_00};
      tbl[1]  = '{lu_exec,                            10'b111_000_00_00};
      tbl[2]  = '{mk(5,0,0,0, 5,0,0, 1,0,0, 1,0, 0), 10'b000_000_00_00};
      tbl[3]  = '{mk(0,0,1,0, 0,0,0, 1,0,0, 1,0, 0), 10'b000_000_00_00};
      tbl[4]  = '{mk(0,9,0,1, 0,9,0, 0,1,0, 0,1, 0), 10'b111_000_00_00};
      tbl[5]  = '{mk(0,7,0,0, 0,7,7, 0,1,1, 0,0, 0), 10'b000_000_00_01};
      tbl[6]  = '{mk(0,7,0,0, 0,0,7, 0,1,1, 0,0, 0), 10'b000_000_00_10};
      tbl[7]  = '{mk(3,0,0,0, 0,3,3, 0,0,1, 0,0, 0), 10'b000_000_10_00};
      tbl[8]  = '{mk(3,3,0,0, 0,3,0, 0,1,0, 0,0, 0), 10'b000_000_01_01};
      tbl[9]  = '{mk(5,0,1,0, 5,0,0, 1,0,0, 1,0, 1), 10'b000_111_00_00};
      tbl[10] = '{mk(6,0,1,0, 6,0,0, 0,0,0, 1,0, 0), 10'b000_000_00_00};
      tbl[11] = '{mk(0,0,1,1, 0,0,0, 0,0,1, 0,0, 0), 10'b000_000_00_00};
      tbl[12] = '{mk(4,0,1,0, 4,4,0, 1,1,0, 1,0, 0), 10'b111_000_01_00};
      tbl[13] = '{mk(2,0,1,0, 0,2,2, 0,1,1, 0,1, 0), 10'b111_000_10_00};

      // Reset state
      drive('0);
      #1;
      chk("rst_halted", 32'(halted), 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_outs", 32'(outs()), 0);
      do_reset();

      // Combinational table (stays in RUN: halt_if never set)
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].i);
         #1;
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].o));
      end

      // Load-use at distance 1 then distance 2
      do_reset();
      drive(lu_exec); #1;
      chk("lu_dist1", {stall_if, stall_dec, bubble_exec}, 3'b111);
      @(negedge clk); drive(lu_mem); #1;
      chk("lu_dist2", {stall_if, stall_dec, bubble_exec}, 3'b111);
      @(negedge clk); drive('0); #1;
      chk("lu_clear", {stall_if, stall_dec, bubble_exec}, 3'b000);
      chk("lu_stall_cnt", stall_cnt, 2);

      // Redirect with simultaneous hazard
      do_reset();
      v = lu_exec; v.redir = 1'b1;
      drive(v); #1;
      chk("redir_over_haz", {flush_dec, flush_exec, flush_mem, stall_if, stall_dec, bubble_exec}, 6'b111000);
      @(negedge clk); drive('0); #1;
      chk("redir_flush_cnt", flush_cnt, 1);
      chk("redir_stall_cnt", stall_cnt, 0);

      // Halt: halted exactly HD cycles after the sampling edge
      do_reset();
      hv = '0; hv.halt = 1'b1;
      drive(hv); #1;
      chk("halt_run_si", 32'(stall_if), 0);
      @(negedge clk); drive('0); #1;
      chk("drain_si", 32'(stall_if), 1);
      chk("drain_halted", 32'(halted), 0);
      for (int k = 1; k <= HD; k++) begin
         @(negedge clk); #1;
         chk($sformatf("halt_t%0d", k), 32'(halted), (k == HD) ? 32'd1 : 32'd0);
      end
      v = lu_exec; v.redir = 1'b1;
      drive(v); #1;
      chk("halted_outs", {halted, stall_if, stall_dec, bubble_exec, flush_dec, flush_exec, flush_mem}, 7'b1111000);
      @(negedge clk); #1;
      chk("halted_flush_cnt", flush_cnt, 0);
      chk("halted_stall_cnt", stall_cnt, 0);
      #1 rstn = 1'b0;
      #1;
      chk("rst_in_halted", 32'(halted), 0);
      do_reset();

      // Halt together with redirect is ignored
      hv.redir = 1'b1;
      drive(hv);
      @(negedge clk); drive('0); #1;
      chk("halt_redir_ignored", 32'(stall_if), 0);

      // Redirect in 2nd drain cycle cancels the halt
      do_reset();
      hv = '0; hv.halt = 1'b1;
      drive(hv);
      @(negedge clk); drive('0);
      @(negedge clk); v = '0; v.redir = 1'b1; drive(v); #1;
      chk("drain_cancel", {flush_dec, flush_exec, flush_mem, stall_if}, 4'b1110);
      @(negedge clk); drive('0); #1;
      chk("back_to_run", 32'(stall_if), 0);
      seen = 0;
      repeat (8) begin
         @(negedge clk); #1;
         seen |= halted;
      end
      chk("never_halted", 32'(seen), 0);

      // Saturation from a preloaded near-full value
      do_reset();
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      force dut.flush_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      release dut.flush_cnt_q;
      drive(lu_exec);
      repeat (3) @(negedge clk);
      v = '0; v.redir = 1'b1;
      drive(v);
      repeat (3) @(negedge clk);
      drive('0); #1;
      chk("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
      chk("flush_cnt_sat", flush_cnt, 32'hFFFF_FFFF);

      // Randomized run against the reference model
      do_reset();
      m_reset();
      for (int c = 0; c < 600; c++) begin
         if (m_mode == M_HALT && $urandom_range(0, 3) == 0) begin
            do_reset();
            m_reset();
         end
         v       = '0;
         v.rs1   = 5'($urandom_range(0, 3));
         v.rs2   = 5'($urandom_range(0, 3));
         v.u1    = 1'($urandom_range(0, 1));
         v.u2    = 1'($urandom_range(0, 1));
         v.rde   = 5'($urandom_range(0, 3));
         v.rdm   = 5'($urandom_range(0, 3));
         v.rdw   = 5'($urandom_range(0, 3));
         v.we    = 1'($urandom_range(0, 1));
         v.wm    = 1'($urandom_range(0, 1));
         v.ww    = 1'($urandom_range(0, 1));
         v.le    = 1'($urandom_range(0, 1));
         v.lm    = 1'($urandom_range(0, 1));
         v.redir = ($urandom_range(0, 7) == 0);
         v.halt  = ($urandom_range(0, 9) == 0);
         drive(v);
         #1;
         e = m_out(v);
         chk($sformatf("rnd%0d_outs", c), 32'(outs()), 32'(e));
         chk($sformatf("rnd%0d_halted", c), 32'(halted), (m_mode == M_HALT) ? 32'd1 : 32'd0);
         chk($sformatf("rnd%0d_stall_cnt", c), stall_cnt, 32'(m_sc));
         chk($sformatf("rnd%0d_flush_cnt", c), flush_cnt, 32'(m_fc));
         m_step(v);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter HALT_DRAIN, default 4, drain cycles after halt detection (range 1..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rs1_dec, rs2_dec  input  REG_AW  source registers of the decode-stage instruction.
REQ-006 SHALL have ports rs1_used, rs2_used  input  1  decode instruction reads rs1/rs2.
REQ-007 SHALL have ports rd_exec, rd_mem, rd_wb  input  REG_AW  destinations in Exec/Mem/WB.
REQ-008 SHALL have ports wen_exec, wen_mem, wen_wb  input  1  register-write enables in Exec/Mem/WB.
REQ-009 SHALL have ports load_exec, load_mem  input  1  instruction in Exec/Mem is a load.
REQ-010 SHALL have port redirect_mem  input  1  taken branch/jump resolved in Mem.
REQ-011 SHALL have port halt_if  input  1  fetch detected a halt instruction.
REQ-012 SHALL have ports stall_if, stall_dec  output  1  hold PC and the IF/Dec register.
REQ-013 SHALL have port bubble_exec  output  1  load a NOP into the Dec/Exec register.
REQ-014 SHALL have ports flush_dec, flush_exec, flush_mem  output  1  clear IF/Dec, Dec/Exec, Exec/Mem registers.
REQ-015 SHALL have ports fwd_a_sel, fwd_b_sel  output  2  operand source: 00 regfile, 01 Mem ALU result, 10 WB write data.
REQ-016 SHALL have port halted  output  1  pipeline drained and stopped.
REQ-017 SHALL have ports stall_cnt, flush_cnt  output  32  saturating performance counters.

Function
REQ-018 SHALL treat register 0 as never hazarding and never forwarded.
REQ-019 SHALL assert load-use hazard when a used rs matches rd_exec with load_exec&wen_exec, or matches rd_mem with load_mem&wen_mem (2 stall cycles at distance 1, 1 at distance 2).
REQ-020 SHALL, on hazard without redirect, assert stall_if, stall_dec and bubble_exec combinationally in that cycle.
REQ-021 SHALL select fwd_x_sel: 01 if rd_mem matches, wen_mem=1, load_mem=0; else 10 if rd_wb matches and wen_wb=1; else 00; Mem beats WB.
REQ-022 SHALL, when redirect_mem=1, assert flush_dec, flush_exec, flush_mem in that cycle and suppress stall_if, stall_dec and bubble_exec.
REQ-023 SHALL implement FSM states RUN, DRAIN, HALTED.
REQ-024 SHALL in RUN move to DRAIN on halt_if=1 with redirect_mem=0; halt_if with redirect_mem=1 is ignored.
REQ-025 SHALL on DRAIN entry load the drain counter with HALT_DRAIN; in DRAIN hold stall_if=1, decrement each cycle, enter HALTED on the cycle the count reaches 0.
REQ-026 SHALL in DRAIN return to RUN with flushes per REQ-022 if redirect_mem=1 (speculative halt cancelled).
REQ-027 SHALL in DRAIN continue applying hazard stalls; the drain counter SHALL NOT decrement in stall cycles.
REQ-028 SHALL in HALTED hold halted, stall_if, stall_dec, bubble_exec at 1 and ignore all inputs until reset.
REQ-029 SHALL increment stall_cnt each cycle stall_dec=1 outside HALTED, and flush_cnt each cycle redirect_mem=1; both saturate at 0xFFFFFFFF.

Reset
REQ-030 SHALL on rstn=0 asynchronously force state RUN, drain counter 0, stall_cnt=0, flush_cnt=0, halted=0.
REQ-031 SHALL hold all combinational outputs per RUN rules during reset; reset mid-DRAIN or in HALTED returns to RUN.

Structure
REQ-032 SHALL place FSM state encoding and fwd select codes (FWD_RF, FWD_MEM, FWD_WB) in the shared pipeline package.
REQ-033 SHALL contain one sub-module, hazard_fwd_unit (purely combinational hazard and forwarding logic); FSM and counters in pipeline_ctrl.

Verification
REQ-034 SHALL cover: rd_exec=5, load_exec=1, wen_exec=1, rs1_dec=5, rs1_used=1 -> stall_if/stall_dec/bubble_exec=1; next cycle as load_mem -> 1 more stall; stall_cnt=2.
REQ-035 SHALL cover: rd_mem=7, wen_mem=1, load_mem=0, rd_wb=7, wen_wb=1, rs2_dec=7 -> fwd_b_sel=01; rd_mem=0 -> fwd_b_sel=10.
REQ-036 SHALL cover: redirect_mem=1 with simultaneous load-use hazard -> all three flushes=1, stalls=0, flush_cnt=1.
REQ-037 SHALL cover: halt_if=1 in RUN, no hazards -> halted=1 exactly HALT_DRAIN=4 cycles later; halt_if with redirect_mem=1 -> stays RUN.
REQ-038 SHALL cover: halt_if, then redirect_mem=1 in 2nd DRAIN cycle -> RUN, halted never 1; rstn low in HALTED -> halted=0 immediately.
REQ-039 SHALL cover: counter preload 0xFFFFFFFE, 3 stall cycles -> stall_cnt=0xFFFFFFFF.
